// File: rtl/csa_accum_ctrl_pkg.sv
// Shared types and constants for the carry-save accumulator controller.
package csa_ctrl_pkg;

  localparam int unsigned LANES     = 3;
  localparam int unsigned DEF_WIDTH = 11;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Beat input / result output bundle for csa_accum_ctrl.
interface csa_accum_ctrl_if #(
  parameter int unsigned WIDTH = csa_ctrl_pkg::DEF_WIDTH,
  parameter int unsigned CNT_W = csa_ctrl_pkg::DEF_CNT_W
);
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                in_op0;
  logic [WIDTH-1:0]                in_op1;
  logic [WIDTH-1:0]                in_op2;
  logic [csa_ctrl_pkg::LANES-1:0]  in_mask;
  logic                            in_last;
  logic                            abort;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                out_result;
  logic [CNT_W-1:0]                out_beats;

  modport master (
    output in_valid, in_op0, in_op1, in_op2, in_mask, in_last, abort, out_ready,
    input  in_ready, out_valid, out_result, out_beats
  );

  modport slave (
    input  in_valid, in_op0, in_op1, in_op2, in_mask, in_last, abort, out_ready,
    output in_ready, out_valid, out_result, out_beats
  );
endinterface

// File: rtl/csa_accum_ctrl_csa52.sv
// 5:2 compressor: sum + 2*carry == x0+x1+x2+x3+x4 (mod 2^WIDTH), carry-ins tied low.
module csa_5_2 #(
  parameter int unsigned WIDTH = csa_ctrl_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic ci1, ci2, s1, s2, co1, co2;

  // Three cascaded full adders per bit; the two lateral carries ripple to bit i+1.
  always_comb begin
    sum   = '0;
    carry = '0;
    ci1   = 1'b0;
    ci2   = 1'b0;
    s1    = 1'b0;
    s2    = 1'b0;
    co1   = 1'b0;
    co2   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1       = x0[i] ^ x1[i] ^ x2[i];
      co1      = (x0[i] & x1[i]) | (x0[i] & x2[i]) | (x1[i] & x2[i]);
      s2       = s1 ^ x3[i] ^ ci1;
      co2      = (s1 & x3[i]) | (s1 & ci1) | (x3[i] & ci1);
      sum[i]   = s2 ^ x4[i] ^ ci2;
      carry[i] = (s2 & x4[i]) | (s2 & ci2) | (x4[i] & ci2);
      ci1      = co1;
      ci2      = co2;
    end
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Accumulates three masked operand lanes per beat in carry-save form,
// resolving with one carry-propagate add after the last beat.
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  csa_accum_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic             live_q;
  logic             accept, consume;
  logic [WIDTH-1:0] s_q, c_q;
  logic [WIDTH-1:0] lane0, lane1, lane2;
  logic [WIDTH-1:0] csa_sum, csa_carry;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] beats_q;

  // AND-masking keeps disabled lanes at zero even when their data is unknown.
  assign lane0 = bus.in_op0 & {WIDTH{bus.in_mask[0]}};
  assign lane1 = bus.in_op1 & {WIDTH{bus.in_mask[1]}};
  assign lane2 = bus.in_op2 & {WIDTH{bus.in_mask[2]}};

  csa_5_2 #(.WIDTH(WIDTH)) u_csa (
    .x0    (s_q),
    .x1    (c_q << 1),
    .x2    (lane0),
    .x3    (lane1),
    .x4    (lane2),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // live_q holds in_ready low for the first cycle after reset release.
  assign bus.in_ready   = live_q && (state_q == IDLE || state_q == ACCUM);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_beats  = beats_q;
  assign accept         = bus.in_valid && bus.in_ready;
  assign consume        = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = bus.in_last ? RESOLVE : ACCUM;
      RESOLVE:     state_d = DONE;
      DONE:        if (consume) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (bus.abort || consume) begin
        s_q   <= '0;
        c_q   <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        s_q <= csa_sum;
        c_q <= csa_carry;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == RESOLVE) begin
        result_q <= s_q + (c_q << 1);
        beats_q  <= cnt_q;
      end
    end
  end

endmodule
